// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: sample width, phase/count widths, zero sample.
package fir_pkg;

    localparam int unsigned WI_DEF   = 1;
    localparam int unsigned WF_DEF   = 15;
    localparam int unsigned SAMPLE_W = WI_DEF + WF_DEF;

    localparam logic [SAMPLE_W-1:0] ZERO_SAMPLE = '0;

    // Width of the frame phase counter; the FIR core uses the same encoding.
    function automatic int unsigned phase_w(input int unsigned taps);
        return (taps < 2) ? 1 : $clog2(taps);
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Valid/ready sample handshake between a sample source and the feeder.
interface fir_sample_feeder_if #(
    parameter int unsigned W = 16
) ();

    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/fir_sample_feeder_sample_fifo.sv
// Small synchronous FIFO; push when full and pop when empty are ignored.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [W-1:0]                i_data,
    output logic [W-1:0]                o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [count_w(DEPTH)-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; contents need no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy tracks push/pop on the same edge; both together leave it unchanged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds one sample per TAPSIZE-cycle frame to the FIR, zero-filling and flagging underruns.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int unsigned TAPSIZE = 3,
    parameter int unsigned WI      = WI_DEF,
    parameter int unsigned WF      = WF_DEF,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    fir_sample_feeder_if.slave            s_in,
    output logic signed [WI+WF-1:0]       x,
    output logic                          x_strobe,
    output logic                          x_real,
    output logic [phase_w(TAPSIZE)-1:0]   phase,
    output logic [count_w(DEPTH)-1:0]     count,
    output logic                          underrun,
    input  logic                          underrun_clr
);

    localparam int unsigned W  = WI + WF;
    localparam int unsigned PW = phase_w(TAPSIZE);
    localparam logic [PW-1:0] PH_LAST = PW'(TAPSIZE - 1);

    logic [PW-1:0]       r_phase;
    logic signed [W-1:0] r_x;
    logic                r_x_strobe;
    logic                r_x_real;
    logic                r_underrun;

    logic                w_boundary;
    logic                w_push;
    logic [W-1:0]        w_head;
    logic                w_full;
    logic                w_empty;
    logic [count_w(DEPTH)-1:0] w_count;

    assign w_boundary    = (r_phase == PH_LAST);
    assign w_push        = s_in.in_valid && !w_full;
    assign s_in.in_ready = !w_full;

    // Pop request is the boundary itself; the FIFO ignores it when empty, and
    // emptiness is judged before this edge's push, so there is no fall-through.
    sample_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_boundary),
        .i_data  (s_in.in_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Free-running frame phase, wrapping after the boundary cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_phase <= '0;
        end else if (w_boundary) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Load x once per frame: head sample if available, otherwise zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_x        <= '0;
            r_x_strobe <= 1'b0;
            r_x_real   <= 1'b0;
        end else begin
            r_x_strobe <= w_boundary;
            if (w_boundary) begin
                if (w_empty) begin
                    r_x      <= W'(ZERO_SAMPLE);
                    r_x_real <= 1'b0;
                end else begin
                    r_x      <= w_head;
                    r_x_real <= 1'b1;
                end
            end
        end
    end

    // Sticky underrun; a new underrun takes priority over a clear on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_underrun <= 1'b0;
        end else if (w_boundary && w_empty) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign x        = r_x;
    assign x_strobe = r_x_strobe;
    assign x_real   = r_x_real;
    assign phase    = r_phase;
    assign count    = w_count;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench: queue-based frame model checked every cycle plus directed literal checks.
module tb_fir_sample_feeder;
    import fir_pkg::*;

    localparam int TAPSIZE = 3;
    localparam int DEPTH   = 4;
    localparam int W       = 16;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               underrun_clr = 1'b0;
    logic signed [W-1:0] x;
    logic               x_strobe;
    logic               x_real;
    logic [1:0]         phase;
    logic [2:0]         count;
    logic               underrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    fir_sample_feeder_if #(.W(W)) u_if ();

    fir_sample_feeder #(
        .TAPSIZE (TAPSIZE),
        .WI      (1),
        .WF      (15),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .s_in         (u_if.slave),
        .x            (x),
        .x_strobe     (x_strobe),
        .x_real       (x_real),
        .phase        (phase),
        .count        (count),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: a queue of samples and a frame counter.
    logic [W-1:0] mq[$];
    logic [W-1:0] mx;
    logic         mstrobe, mreal, mund;
    int           mphase;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                mq.delete();
                mx = '0; mstrobe = 1'b0; mreal = 1'b0; mund = 1'b0; mphase = 0;
            end
            check("m_x",        $unsigned(x), mx);
            check("m_x_strobe", x_strobe,     mstrobe);
            check("m_x_real",   x_real,       mreal);
            check("m_phase",    phase,        mphase);
            check("m_count",    count,        mq.size());
            check("m_underrun", underrun,     mund);
            check("m_in_ready", u_if.in_ready, (mq.size() < DEPTH));
            if (RST) begin
                automatic bit bnd   = (mphase == TAPSIZE - 1);
                automatic bit empty = (mq.size() == 0);
                automatic bit acc   = u_if.in_valid && (mq.size() < DEPTH);
                mstrobe = bnd;
                if (bnd) begin
                    if (!empty) begin
                        mx = mq.pop_front(); mreal = 1'b1;
                    end else begin
                        mx = '0; mreal = 1'b0; mund = 1'b1;
                    end
                end
                if (!(bnd && empty) && underrun_clr) mund = 1'b0;
                if (acc) mq.push_back(u_if.in_data);
                mphase = (mphase + 1) % TAPSIZE;
            end
        end
    end

    task automatic step();
        @(posedge CLK); #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        underrun_clr  = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int nv;
        int maxc;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;

        // Idle frames: zero-fill every frame, underrun from cycle 3.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge CLK);
            if (c == 0) check("t1_rst_phase", phase, 2'd0);
            if (c == 2) check("t1_und_pre", underrun, 1'b0);
            if (c == 3 || c == 6 || c == 9) begin
                check("t1_strobe", x_strobe, 1'b1);
                check("t1_x",      $unsigned(x), 32'h0);
                check("t1_real",   x_real, 1'b0);
                check("t1_und",    underrun, 1'b1);
            end
            if (c == 4) check("t1_strobe_low", x_strobe, 1'b0);
            step();
        end

        // Single push at cycle 0 appears at cycle 3.
        do_reset();
        u_if.in_valid = 1'b1; u_if.in_data = 16'h4000;
        step();
        u_if.in_valid = 1'b0;
        @(negedge CLK);
        check("t2_count1", count, 3'd1);
        goto(3);
        @(negedge CLK);
        check("t2_x",      $unsigned(x), 32'h4000);
        check("t2_real",   x_real, 1'b1);
        check("t2_strobe", x_strobe, 1'b1);
        check("t2_count0", count, 3'd0);
        check("t2_und",    underrun, 1'b0);

        // Burst 1..6: backpressure, ordered delivery, occupancy capped at DEPTH.
        do_reset();
        nv = 1; maxc = 0;
        for (int c = 0; c < 22; c++) begin
            u_if.in_valid = (nv <= 6);
            u_if.in_data  = 16'(nv);
            @(negedge CLK);
            if (int'(count) > maxc) maxc = int'(count);
            if (u_if.in_valid && u_if.in_ready) nv++;
            if (c == 5) begin
                check("t3_ready_low", u_if.in_ready, 1'b0);
                check("t3_full",      count, 3'd4);
            end
            if (c >= 3 && c <= 18 && (c % 3) == 0) begin
                check("t3_x",    $unsigned(x), c / 3);
                check("t3_real", x_real, 1'b1);
            end
            if (c == 21) check("t3_tail_zero", x_real, 1'b0);
            step();
        end
        u_if.in_valid = 1'b0;
        check("t3_maxcount", maxc, 4);
        check("t3_all_sent", nv, 7);

        // Push during the boundary cycle into an empty FIFO: no fall-through.
        do_reset();
        goto(2);
        u_if.in_valid = 1'b1; u_if.in_data = 16'h1234;
        step();
        u_if.in_valid = 1'b0;
        @(negedge CLK);
        check("t4_x0",    $unsigned(x), 32'h0);
        check("t4_real0", x_real, 1'b0);
        check("t4_und",   underrun, 1'b1);
        check("t4_cnt",   count, 3'd1);
        goto(6);
        @(negedge CLK);
        check("t4_x",     $unsigned(x), 32'h1234);
        check("t4_real",  x_real, 1'b1);

        // Mid-frame reset with samples queued discards them.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            u_if.in_valid = 1'b1; u_if.in_data = 16'(17 * (c + 1));
            step();
        end
        u_if.in_valid = 1'b0;
        @(negedge CLK);
        check("t5_queued", count, 3'd3);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t5_rst_cnt",   count, 3'd0);
        check("t5_rst_x",     $unsigned(x), 32'h0);
        check("t5_rst_phase", phase, 2'd0);
        check("t5_rst_rdy",   u_if.in_ready, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        cyc = 0;
        goto(3);
        @(negedge CLK);
        check("t5_x",    $unsigned(x), 32'h0);
        check("t5_real", x_real, 1'b0);
        check("t5_und",  underrun, 1'b1);
        goto(6);
        @(negedge CLK);
        check("t5_real6", x_real, 1'b0);

        // Clear while data present; then clear colliding with a new underrun.
        goto(7);
        u_if.in_valid = 1'b1; u_if.in_data = 16'h0777;
        underrun_clr  = 1'b1;
        step();
        u_if.in_valid = 1'b0;
        underrun_clr  = 1'b0;
        @(negedge CLK);
        check("t6_cleared", underrun, 1'b0);
        goto(9);
        @(negedge CLK);
        check("t6_x",    $unsigned(x), 32'h0777);
        check("t6_und9", underrun, 1'b0);
        goto(11);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        @(negedge CLK);
        check("t6_set_wins", underrun, 1'b1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
